// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, resolves opcode-11 jumps at fetch time
// and buffers {instruction, PC+1} pairs so decode can stall without refetching.
module fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 8,
  parameter int                INS_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INS_W-1:0]         imem_data,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INS_W-1:0]         out_ins,
  output logic [ADDR_W-1:0]        out_pc1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_plus1;
  logic              push, pop, is_jump;

  logic [INS_W-1:0]  ins_mem [DEPTH];
  logic [ADDR_W-1:0] pc1_mem [DEPTH];

  // A full queue never accepts a push even when the head pops in the same
  // cycle, which keeps out_ready off the instruction memory address path.
  always_comb begin
    pc_plus1   = fetch_pc_q + ADDR_W'(1);
    is_jump    = (imem_data[INS_W-1 -: 2] == 2'b11);
    push       = !redirect_valid && (count_q < CNT_W'(DEPTH));
    pop        = (count_q != '0) && out_ready && !redirect_valid;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = is_jump ? {fetch_pc_q[ADDR_W-1:6], imem_data[5:0]} : pc_plus1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[wr_ptr_q] <= imem_data;
      pc1_mem[wr_ptr_q] <= pc_plus1;
    end
  end

  always_comb begin
    imem_addr = fetch_pc_q;
    count     = count_q;
    out_valid = (count_q != '0);
    out_ins   = out_valid ? ins_mem[rd_ptr_q] : '0;
    out_pc1   = out_valid ? pc1_mem[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a queue-based reference model predicts each entry,
// and a monitor compares the DUT head, occupancy and fetch address against it.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] imemAddr, imemData;
  logic       redirectValid;
  logic [7:0] redirectPc;
  logic       outValid, outReady;
  logic [7:0] outIns, outPc1;
  logic [2:0] count;

  logic [7:0] mem [256];

  typedef struct packed {
    logic [7:0] ins;
    logic [7:0] pc1;
  } entry_t;

  entry_t     expQ[$];
  entry_t     pendEntry;
  bit         havePush;
  bit         inReset;
  logic [7:0] modelPc, nextPc;
  int         tests = 0;
  int         fails = 0;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(8), .INS_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .imem_addr(imemAddr), .imem_data(imemData),
    .redirect_valid(redirectValid), .redirect_pc(redirectPc),
    .out_valid(outValid), .out_ready(outReady), .out_ins(outIns),
    .out_pc1(outPc1), .count(count)
  );

  always #5 clk = ~clk;

  assign imemData = mem[imemAddr];

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Where the program goes after fetching from pc: opcode 11 jumps within the 64-byte page.
  function automatic logic [7:0] fetchNext(input logic [7:0] pc);
    logic [7:0] ins;
    ins = mem[pc];
    if (ins[7:6] == 2'b11) return {pc[7:6], ins[5:0]};
    return pc + 8'd1;
  endfunction

  // Drive one cycle of inputs at the falling edge, then account for the rising edge in the model.
  task automatic applyStimulus(input bit rdy, input bit redir, input logic [7:0] rpc);
    @(negedge clk);
    outReady      = rdy;
    redirectValid = redir;
    redirectPc    = rpc;
    #1;
    havePush = !redir && (expQ.size() < DEPTH);
    if (havePush) begin
      pendEntry = '{ins: mem[modelPc], pc1: modelPc + 8'd1};
      nextPc    = fetchNext(modelPc);
    end
    @(posedge clk);
    if (redir) begin
      expQ.delete();
      modelPc = rpc;
    end else if (havePush) begin
      expQ.push_back(pendEntry);
      modelPc = nextPc;
    end
  endtask

  task automatic checkResetState();
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_out_ins", outIns, 0);
    checkOutput("reset_out_pc1", outPc1, 0);
    checkOutput("reset_imem_addr", imemAddr, 8'h00);
  endtask

  // Monitor: mid-low-phase, after inputs settle; pops the scoreboard on each accepted head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!inReset) begin
        checkOutput("imem_addr", imemAddr, modelPc);
        checkOutput("count", count, expQ.size());
        checkOutput("out_valid", outValid, int'(expQ.size() != 0));
        if (expQ.size() != 0) begin
          checkOutput("out_ins", outIns, expQ[0].ins);
          checkOutput("out_pc1", outPc1, expQ[0].pc1);
          if (outReady && !redirectValid) void'(expQ.pop_front());
        end else begin
          checkOutput("out_ins_empty", outIns, 0);
          checkOutput("out_pc1_empty", outPc1, 0);
        end
      end
    end
  end

  initial begin
    bit         rdy;
    logic [7:0] rpc;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h32; mem[8'h01] = 8'h56; mem[8'h02] = 8'h62; mem[8'h03] = 8'hC5;
    mem[8'h04] = 8'h34; mem[8'h05] = 8'h74; mem[8'h06] = 8'h00; mem[8'h7F] = 8'hC5;
    mem[8'hFF] = 8'h41; mem[8'h40] = 8'h4A;

    inReset = 1'b1; reset = 1'b0; outReady = 1'b0; redirectValid = 1'b0; redirectPc = 8'h00;
    #3;
    checkResetState();
    @(posedge clk); #3;
    expQ.delete(); modelPc = 8'h00; reset = 1'b1; inReset = 1'b0;

    // Straight-line fetch through the jump at address 3.
    repeat (8) applyStimulus(1'b1, 1'b0, 8'h00);

    // Fill, single pop, refill; then redirect with entries pending.
    applyStimulus(1'b1, 1'b1, 8'h00);
    repeat (6) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h40);
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);

    // Address wrap and page-relative jump.
    applyStimulus(1'b1, 1'b1, 8'hFF);
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h7F);
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);

    // Held redirect, then redirect racing a pop with entries queued.
    repeat (3) applyStimulus(1'b1, 1'b1, 8'($urandom));
    applyStimulus(1'b0, 1'b1, 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h00);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);

    // Asynchronous reset between edges with three entries queued.
    #3;
    inReset = 1'b1;
    reset   = 1'b0;
    #1;
    checkResetState();
    @(posedge clk); #3;
    expQ.delete(); modelPc = 8'h00; reset = 1'b1; inReset = 1'b0;
    repeat (8) applyStimulus(1'b1, 1'b0, 8'h00);

    // Randomized traffic with phases of heavy and light back-pressure.
    for (int phase = 0; phase < 40; phase++) begin
      int readyOdds;
      readyOdds = $urandom_range(0, 4);
      for (int c = 0; c < 50; c++) begin
        rdy = ($urandom_range(0, 3) < readyOdds);
        case ($urandom_range(0, 3))
          0:       rpc = 8'hFF;
          1:       rpc = 8'h7F;
          2:       rpc = 8'h00;
          default: rpc = 8'($urandom);
        endcase
        applyStimulus(rdy, ($urandom_range(0, 15) == 0), rpc);
      end
    end

    @(negedge clk); #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end feeding the IF/ID pipeline register of the 8-bit pipelined processor.
- Owns the fetch PC, drives the instruction memory read address and resolves opcode-11 jumps at fetch time.
- Buffers fetched {instruction, PC+1} pairs in a small FIFO so decode can stall without refetching.
- Also accepts an external redirect that flushes the queue and restarts fetch.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- ADDR_W, 8, PC / instruction memory address width.
- INS_W, 8, instruction width.
- RESET_PC, 8'h00, fetch PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- imem_addr  out  ADDR_W  instruction memory read address; equals fetch_pc (combinational from register).
- imem_data  in  INS_W  instruction memory data for imem_addr, valid in the same cycle (combinational read).
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  restart address.
- out_valid  out  1  head entry available.
- out_ready  in  1  decode accepts head entry.
- out_ins  out  INS_W  head instruction; 0 when empty.
- out_pc1  out  ADDR_W  head PC+1; 0 when empty.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, reset==0), effective immediately:
  - fetch_pc=RESET_PC, so imem_addr=RESET_PC.
  - count=0, rd/wr pointers=0.
  - out_valid=0, out_ins=0, out_pc1=0.
  - Storage contents are don't-care.
- push = !redirect_valid && (count < DEPTH). Full-queue push is never bypassed by a same-cycle pop, so there is no out_ready-to-imem path.
- On push (at posedge):
  - Write {imem_data, fetch_pc+1} at wr_ptr; wr_ptr advances.
  - If imem_data[7:6]==2'b11: fetch_pc <= {fetch_pc[7:6], imem_data[5:0]}.
  - Otherwise: fetch_pc <= fetch_pc+1, mod 256 (8'hFF -> 8'h00).
- No push: fetch_pc holds (stall).
- Jump instructions are still enqueued. Decode must treat opcode 11 as already resolved and must not redirect on it.
- pop = out_valid && out_ready && !redirect_valid. On pop, rd_ptr advances.
- out_valid = (count != 0). out_ins/out_pc1 are taken from the head entry, masked to 0 when empty.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: an instruction fetched at edge N is visible on out_* after edge N (one cycle after imem_addr presents it).
- Throughput: 1 instruction/cycle when out_ready is held at 1.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never goes below 0.
- Pop on empty has no effect.
- redirect_valid=1 at posedge (has priority over push and pop):
  - count=0, pointers=0.
  - fetch_pc <= redirect_pc.
  - Next cycle: out_valid=0 and imem_addr=redirect_pc.
  - Cycle after that: out_valid=1 with mem[redirect_pc], provided the redirect is deasserted.
- Redirect held for multiple cycles: the queue stays empty and fetch_pc tracks redirect_pc.
- Reset mid-operation: all in-flight entries are discarded and no partial state remains. Fetch resumes from RESET_PC on the first edge after release.

Test Plan:
Memory image for all scenarios: mem[0]=0x32, [1]=0x56, [2]=0x62, [3]=0xC5, [4]=0x34, [5]=0x74, [6]=0x00, [0x7F]=0xC5, [0xFF]=0x41, [0x40]=0x4A.
1. Release reset, out_ready=1 → out_ins/out_pc1 sequence 0x32/1, 0x56/2, 0x62/3, 0xC5/4, 0x74/6, 0x00/7. imem_addr never equals 4.
2. Release reset, out_ready=0 → count reaches 4 after 4 edges and holds; imem_addr=5; out_ins=0x32. Then pulse out_ready for one cycle → count=3, then 4 on the next edge, with 0x74 enqueued last.
3. Queue at count=3, redirect_valid=1 with redirect_pc=0x40 for one cycle → next cycle count=0, out_valid=0, imem_addr=0x40. Following cycle: out_ins=0x4A, out_pc1=0x41.
4. Redirect to 0xFF, out_ready=1 → out_ins=0x41 with out_pc1=0x00, followed by 0x32 (wrap). Redirect to 0x7F → 0xC5 with out_pc1=0x80; next fetch address is 0x45 (upper bits 01 kept).
5. redirect_valid and out_ready both 1 with count=2 → pop is ignored and count=0. Occupancy never underflows.
6. Assert reset between clock edges with count=3 → out_valid=0, count=0, out_ins=0, imem_addr=0x00 immediately (no edge needed). After release, scenario 1's sequence repeats exactly.
